// File: rtl/lpc_capture_ctrl.sv
// ---------------------------------------------------------------------------
// lpc_capture_ctrl
//
// Captures completed LPC I/O and memory transactions from an upstream decoder,
// queues them as 30-bit records in a small FIFO and serialises each record
// onto a byte stream as four bytes:
//   HDR = {cyctype_dir[3:0], timeout, ovf, 2'b00}
//   AHI = addr[15:8]
//   ALO = addr[7:0]
//   DAT = data
//
// Ports
//   lpc_clock        in   sole clock, rising edge
//   lpc_reset        in   asynchronous active-low reset
//   enable           in   capture enable (blocks new captures only)
//   in_strobe        in   transaction-done level, a 0->1 edge marks one transaction
//   in_cyctype_dir   in   [3:0] cycle type / direction
//   in_addr          in   [31:0] decoded address, only [15:0] is used
//   in_data          in   [7:0] data byte
//   in_sync_timeout  in   transaction ended by sync timeout
//   tx_data          out  [7:0] serialised record byte (registered)
//   tx_valid         out  tx_data valid (registered)
//   tx_ready         in   sink accepts the byte when high together with tx_valid
//   fifo_level       out  [6:0] records waiting in the FIFO
//   dropped_cnt      out  [7:0] records dropped on a full FIFO, saturating
// ---------------------------------------------------------------------------
module lpc_capture_ctrl #(
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] ADDR_LO    = 16'h0000,
    parameter logic [15:0] ADDR_HI    = 16'hFFFF
) (
    input  logic        lpc_clock,
    input  logic        lpc_reset,
    input  logic        enable,
    input  logic        in_strobe,
    input  logic [3:0]  in_cyctype_dir,
    input  logic [31:0] in_addr,
    input  logic [7:0]  in_data,
    input  logic        in_sync_timeout,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [6:0]  fifo_level,
    output logic [7:0]  dropped_cnt
);

    localparam int         AW      = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [6:0] DEPTH_L = 7'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR  = 3'd1,
        S_AHI  = 3'd2,
        S_ALO  = 3'd3,
        S_DAT  = 3'd4
    } state_t;

    // Record layout: [29:26] cyctype_dir, [25] timeout, [24] ovf,
    //                [23:8] addr[15:0], [7:0] data
    function automatic logic [7:0] rec_byte(input state_t st, input logic [29:0] rec);
        logic [7:0] b;
        case (st)
            S_HDR:   b = {rec[29:24], 2'b00};
            S_AHI:   b = rec[23:16];
            S_ALO:   b = rec[15:8];
            S_DAT:   b = rec[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // Registered state
    state_t        state_q,    state_d;
    logic [29:0]   hold_q,     hold_d;
    logic [7:0]    tx_data_q,  tx_data_d;
    logic          tx_valid_q, tx_valid_d;
    logic [AW-1:0] wr_ptr_q,   wr_ptr_d;
    logic [AW-1:0] rd_ptr_q,   rd_ptr_d;
    logic [6:0]    level_q,    level_d;
    logic [7:0]    dropped_q,  dropped_d;
    logic          pend_ovf_q, pend_ovf_d;
    logic          prev_stb_q, prev_stb_d;
    logic          seen_low_q, seen_low_d;
    logic [29:0]   mem_q [FIFO_DEPTH];

    // Combinational helpers
    logic [15:0] addr_s;
    logic [16:0] lo_diff_s;
    logic [16:0] hi_diff_s;
    logic        in_range_s;
    logic        capture_s;
    logic        handshake_s;
    logic        pop_s;
    logic        wr_s;
    logic        rej_s;
    logic [29:0] new_rec_s;
    logic [29:0] head_s;
    logic        unused_addr_s;

    assign unused_addr_s = ^in_addr[31:16];

    // Capture qualification and FIFO write/pop arbitration.
    // The range test uses 17-bit differences so that full-range parameters
    // do not produce constant comparisons.
    // seen_low_q keeps a strobe that is already high when reset releases
    // from counting as a rising edge.
    always_comb begin
        addr_s      = in_addr[15:0];
        lo_diff_s   = {1'b0, addr_s} - {1'b0, ADDR_LO};
        hi_diff_s   = {1'b0, ADDR_HI} - {1'b0, addr_s};
        in_range_s  = ~lo_diff_s[16] & ~hi_diff_s[16];
        capture_s   = in_strobe & ~prev_stb_q & seen_low_q & enable &
                      (in_cyctype_dir[3:2] == 2'b00) & in_range_s;
        handshake_s = tx_valid_q & tx_ready;
        pop_s       = (level_q != 7'd0) &
                      ((state_q == S_IDLE) | ((state_q == S_DAT) & handshake_s));
        // A full FIFO still accepts a write when the head leaves on the same edge.
        wr_s        = capture_s & ((level_q != DEPTH_L) | pop_s);
        rej_s       = capture_s & ~wr_s;
        new_rec_s   = {in_cyctype_dir, in_sync_timeout, pend_ovf_q, addr_s, in_data};
        head_s      = mem_q[rd_ptr_q];
    end

    // FIFO pointers, level, drop counter, overflow flag and strobe history.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        dropped_d  = dropped_q;
        pend_ovf_d = pend_ovf_q;
        prev_stb_d = in_strobe;
        seen_low_d = seen_low_q | ~in_strobe;

        if (wr_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({wr_s, pop_s})
            2'b10:   level_d = level_q + 7'd1;
            2'b01:   level_d = level_q - 7'd1;
            default: level_d = level_q;
        endcase

        if (rej_s) begin
            pend_ovf_d = 1'b1;
            if (dropped_q != 8'hFF) begin
                dropped_d = dropped_q + 8'd1;
            end else begin
                dropped_d = dropped_q;
            end
        end else if (wr_s) begin
            pend_ovf_d = 1'b0;
        end else begin
            pend_ovf_d = pend_ovf_q;
        end
    end

    // Serializer next state; output byte is derived from the next state so
    // tx_data/tx_valid are registered and stay frozen while stalled.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        case (state_q)
            S_IDLE: begin
                if (pop_s) begin
                    state_d = S_HDR;
                    hold_d  = head_s;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_HDR: begin
                if (handshake_s) begin
                    state_d = S_AHI;
                end else begin
                    state_d = S_HDR;
                end
            end
            S_AHI: begin
                if (handshake_s) begin
                    state_d = S_ALO;
                end else begin
                    state_d = S_AHI;
                end
            end
            S_ALO: begin
                if (handshake_s) begin
                    state_d = S_DAT;
                end else begin
                    state_d = S_ALO;
                end
            end
            S_DAT: begin
                // Chain straight into the next record when one is waiting.
                if (handshake_s && pop_s) begin
                    state_d = S_HDR;
                    hold_d  = head_s;
                end else if (handshake_s) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DAT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        tx_valid_d = (state_d != S_IDLE);
        tx_data_d  = rec_byte(state_d, hold_d);
    end

    // Control and output registers.
    always_ff @(posedge lpc_clock or negedge lpc_reset) begin
        if (!lpc_reset) begin
            state_q    <= S_IDLE;
            hold_q     <= 30'd0;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= 7'd0;
            dropped_q  <= 8'd0;
            pend_ovf_q <= 1'b0;
            prev_stb_q <= 1'b0;
            seen_low_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            dropped_q  <= dropped_d;
            pend_ovf_q <= pend_ovf_d;
            prev_stb_q <= prev_stb_d;
            seen_low_q <= seen_low_d;
        end
    end

    // Record storage; contents are qualified by the pointers so no reset is needed.
    always_ff @(posedge lpc_clock) begin
        if (wr_s) begin
            mem_q[wr_ptr_q] <= new_rec_s;
        end
    end

    assign tx_data     = tx_data_q;
    assign tx_valid    = tx_valid_q;
    assign fifo_level  = level_q;
    assign dropped_cnt = dropped_q;

endmodule

// File: tb/tb_lpc_capture_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for lpc_capture_ctrl. Expected output bytes are pushed into a
// scoreboard queue when a capture is driven and compared by a monitor as the
// DUT hands them over. A second instance with a single-address window checks
// the address filter.
// ---------------------------------------------------------------------------
module tb_lpc_capture_ctrl;

    logic        lpc_clock = 1'b0;
    logic        lpc_reset;
    logic        enable;
    logic        in_strobe;
    logic [3:0]  in_cyctype_dir;
    logic [31:0] in_addr;
    logic [7:0]  in_data;
    logic        in_sync_timeout;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [6:0]  fifo_level;
    logic [7:0]  dropped_cnt;

    logic [7:0]  f_tx_data;
    logic        f_tx_valid;
    logic        f_tx_ready;
    logic [6:0]  f_fifo_level;
    logic [7:0]  f_dropped_cnt;

    int          tests_run    = 0;
    int          tests_failed = 0;
    int          flt_bytes    = 0;
    logic [7:0]  exp_q [$];
    logic [7:0]  exp_byte;

    always #5 lpc_clock = ~lpc_clock;

    lpc_capture_ctrl #(.FIFO_DEPTH(8)) u_dut (
        .lpc_clock       (lpc_clock),
        .lpc_reset       (lpc_reset),
        .enable          (enable),
        .in_strobe       (in_strobe),
        .in_cyctype_dir  (in_cyctype_dir),
        .in_addr         (in_addr),
        .in_data         (in_data),
        .in_sync_timeout (in_sync_timeout),
        .tx_data         (tx_data),
        .tx_valid        (tx_valid),
        .tx_ready        (tx_ready),
        .fifo_level      (fifo_level),
        .dropped_cnt     (dropped_cnt)
    );

    lpc_capture_ctrl #(.FIFO_DEPTH(8), .ADDR_LO(16'h0080), .ADDR_HI(16'h0080)) u_flt (
        .lpc_clock       (lpc_clock),
        .lpc_reset       (lpc_reset),
        .enable          (enable),
        .in_strobe       (in_strobe),
        .in_cyctype_dir  (in_cyctype_dir),
        .in_addr         (in_addr),
        .in_data         (in_data),
        .in_sync_timeout (in_sync_timeout),
        .tx_data         (f_tx_data),
        .tx_valid        (f_tx_valid),
        .tx_ready        (f_tx_ready),
        .fifo_level      (f_fifo_level),
        .dropped_cnt     (f_dropped_cnt)
    );

    // Scoreboard monitor: every accepted byte must match the queue head.
    always @(negedge lpc_clock) begin
        if (lpc_reset && tx_valid && tx_ready) begin
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL sb_unexpected: got byte %02h, expected no byte", tx_data);
            end else begin
                exp_byte = exp_q.pop_front();
                if (tx_data !== exp_byte) begin
                    tests_failed++;
                    $display("FAIL sb_byte: got %02h, expected %02h", tx_data, exp_byte);
                end
            end
        end
        if (lpc_reset && f_tx_valid && f_tx_ready) begin
            flt_bytes++;
        end
    end

    task automatic tick();
        @(posedge lpc_clock);
        #1;
    endtask

    task automatic push_rec(input logic [3:0] cyc, input logic [15:0] addr,
                            input logic [7:0] data, input logic to, input logic ovf);
        exp_q.push_back({cyc, to, ovf, 2'b00});
        exp_q.push_back(addr[15:8]);
        exp_q.push_back(addr[7:0]);
        exp_q.push_back(data);
    endtask

    // One strobe pulse (high for one edge, low for one edge).
    task automatic do_cap(input logic [3:0] cyc, input logic [15:0] addr,
                          input logic [7:0] data, input logic to,
                          input bit acc, input logic ovf);
        if (acc) push_rec(cyc, addr, data, to, ovf);
        in_cyctype_dir  = cyc;
        in_addr         = {16'hA5C3, addr};
        in_data         = data;
        in_sync_timeout = to;
        in_strobe       = 1'b1;
        tick();
        in_strobe       = 1'b0;
        tick();
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) tick();
    endtask

    task automatic test_reset();
        lpc_reset = 1'b0; enable = 1'b1; in_strobe = 1'b0; in_cyctype_dir = 4'h0;
        in_addr = 32'h0; in_data = 8'h00; in_sync_timeout = 1'b0;
        tx_ready = 1'b1; f_tx_ready = 1'b1;
        tick(); tick();
        tests_run += 4;
        if (tx_valid !== 1'b0)    begin tests_failed++; $display("FAIL rst_valid: got %b, expected 0", tx_valid); end
        if (tx_data !== 8'h00)    begin tests_failed++; $display("FAIL rst_data: got %02h, expected 00", tx_data); end
        if (fifo_level !== 7'd0)  begin tests_failed++; $display("FAIL rst_level: got %0d, expected 0", fifo_level); end
        if (dropped_cnt !== 8'd0) begin tests_failed++; $display("FAIL rst_dropped: got %0d, expected 0", dropped_cnt); end
        lpc_reset = 1'b1;
        tick(); tick();
    endtask

    task automatic test_single();
        logic [7:0] seq [4];
        seq = '{8'h20, 8'h00, 8'h80, 8'h5A};
        tx_ready = 1'b1;
        push_rec(4'h2, 16'h0080, 8'h5A, 1'b0, 1'b0);
        in_cyctype_dir = 4'h2; in_addr = 32'h0000_0080; in_data = 8'h5A; in_sync_timeout = 1'b0;
        in_strobe = 1'b1;
        tick();  // edge k
        tests_run += 2;
        if (tx_valid !== 1'b0)   begin tests_failed++; $display("FAIL single_k_valid: got %b, expected 0", tx_valid); end
        if (fifo_level !== 7'd1) begin tests_failed++; $display("FAIL single_k_level: got %0d, expected 1", fifo_level); end
        in_strobe = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();  // edges k+1 .. k+4
            tests_run++;
            if (tx_valid !== 1'b1 || tx_data !== seq[i]) begin
                tests_failed++;
                $display("FAIL single_byte%0d: got valid=%b data=%02h, expected valid=1 data=%02h",
                         i, tx_valid, tx_data, seq[i]);
            end
        end
        tick();
        tests_run++;
        if (tx_valid !== 1'b0) begin tests_failed++; $display("FAIL single_end_valid: got %b, expected 0", tx_valid); end
        wait_drain();
        tests_run++;
        if (exp_q.size() != 0) begin tests_failed++; $display("FAIL single_drain: got %0d left, expected 0", exp_q.size()); end
    endtask

    task automatic test_backpressure();
        tx_ready = 1'b1;
        push_rec(4'h2, 16'h00A5, 8'hC3, 1'b0, 1'b0);
        in_cyctype_dir = 4'h2; in_addr = 32'h0000_00A5; in_data = 8'hC3; in_sync_timeout = 1'b0;
        in_strobe = 1'b1;
        tick();
        in_strobe = 1'b0;
        tick();  // HDR shown
        tick();  // AHI shown
        tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tests_run++;
            if (tx_valid !== 1'b1 || tx_data !== 8'h00) begin
                tests_failed++;
                $display("FAIL bp_hold%0d: got valid=%b data=%02h, expected valid=1 data=00", i, tx_valid, tx_data);
            end
            tick();
        end
        tx_ready = 1'b1;
        tick();
        tests_run++;
        if (tx_data !== 8'hA5) begin tests_failed++; $display("FAIL bp_alo: got %02h, expected a5", tx_data); end
        wait_drain();
        tests_run++;
        if (exp_q.size() != 0) begin tests_failed++; $display("FAIL bp_drain: got %0d left, expected 0", exp_q.size()); end
    endtask

    task automatic test_back_to_back();
        tx_ready = 1'b1;
        do_cap(4'h2, 16'h1234, 8'h11, 1'b0, 1'b1, 1'b0);  // edges k, k+1
        do_cap(4'h0, 16'h0056, 8'h22, 1'b1, 1'b1, 1'b0);  // edges k+2, k+3
        tick();  // k+4: first DAT
        tests_run++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h11) begin
            tests_failed++; $display("FAIL b2b_dat: got valid=%b data=%02h, expected valid=1 data=11", tx_valid, tx_data);
        end
        tick();  // k+5: second HDR with no gap
        tests_run++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h08) begin
            tests_failed++; $display("FAIL b2b_hdr: got valid=%b data=%02h, expected valid=1 data=08", tx_valid, tx_data);
        end
        wait_drain();
        tests_run++;
        if (exp_q.size() != 0) begin tests_failed++; $display("FAIL b2b_drain: got %0d left, expected 0", exp_q.size()); end
    endtask

    task automatic test_overflow();
        tx_ready = 1'b0;
        // First capture goes straight into the serializer hold register,
        // the next eight fill the FIFO and the last two are dropped.
        for (int i = 0; i < 11; i++) begin
            do_cap(4'h2, 16'h0100 + 16'(i), 8'(i), 1'b0, (i < 9), 1'b0);
        end
        tests_run += 2;
        if (fifo_level !== 7'd8)  begin tests_failed++; $display("FAIL ovf_level: got %0d, expected 8", fifo_level); end
        if (dropped_cnt !== 8'd2) begin tests_failed++; $display("FAIL ovf_dropped: got %0d, expected 2", dropped_cnt); end
        tx_ready = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        do_cap(4'h2, 16'h0200, 8'h77, 1'b0, 1'b1, 1'b1);  // carries ovf=1
        do_cap(4'h2, 16'h0201, 8'h78, 1'b0, 1'b1, 1'b0);  // ovf cleared again
        wait_drain();
        tests_run += 3;
        if (exp_q.size() != 0)    begin tests_failed++; $display("FAIL ovf_drain: got %0d left, expected 0", exp_q.size()); end
        if (dropped_cnt !== 8'd2) begin tests_failed++; $display("FAIL ovf_dropped_end: got %0d, expected 2", dropped_cnt); end
        tick();
        if (fifo_level !== 7'd0)  begin tests_failed++; $display("FAIL ovf_level_end: got %0d, expected 0", fifo_level); end
    endtask

    task automatic test_filter();
        int start;
        tx_ready = 1'b1;
        start = flt_bytes;
        do_cap(4'h2, 16'h0081, 8'h01, 1'b0, 1'b1, 1'b0);
        do_cap(4'h2, 16'h0080, 8'h02, 1'b0, 1'b1, 1'b0);
        do_cap(4'h8, 16'h0080, 8'h03, 1'b0, 1'b0, 1'b0);
        wait_drain();
        for (int i = 0; i < 10; i++) tick();
        tests_run += 2;
        if (exp_q.size() != 0)       begin tests_failed++; $display("FAIL flt_main_drain: got %0d left, expected 0", exp_q.size()); end
        if (flt_bytes - start != 4)  begin tests_failed++; $display("FAIL flt_bytes: got %0d, expected 4", flt_bytes - start); end
    endtask

    task automatic test_enable_strobe();
        tx_ready = 1'b0;
        do_cap(4'h0, 16'h0010, 8'hA1, 1'b0, 1'b1, 1'b0);
        do_cap(4'h1, 16'h0011, 8'hA2, 1'b0, 1'b1, 1'b0);
        enable = 1'b0;
        do_cap(4'h2, 16'h0012, 8'hA3, 1'b0, 1'b0, 1'b0);
        tests_run++;
        if (fifo_level !== 7'd1) begin tests_failed++; $display("FAIL en_level: got %0d, expected 1", fifo_level); end
        tx_ready = 1'b1;
        wait_drain();
        tests_run++;
        if (exp_q.size() != 0) begin tests_failed++; $display("FAIL en_drain: got %0d left, expected 0", exp_q.size()); end
        enable = 1'b1;
        push_rec(4'h3, 16'h0013, 8'hA4, 1'b0, 1'b0);
        in_cyctype_dir = 4'h3; in_addr = 32'h0000_0013; in_data = 8'hA4; in_sync_timeout = 1'b0;
        in_strobe = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        in_strobe = 1'b0;
        wait_drain();
        for (int i = 0; i < 8; i++) tick();
        tests_run += 2;
        if (exp_q.size() != 0) begin tests_failed++; $display("FAIL held_drain: got %0d left, expected 0", exp_q.size()); end
        if (tx_valid !== 1'b0) begin tests_failed++; $display("FAIL held_valid: got %b, expected 0", tx_valid); end
    endtask

    task automatic test_reset_strobe();
        tx_ready = 1'b1;
        in_cyctype_dir = 4'h2; in_addr = 32'h0000_0044; in_data = 8'h44;
        in_strobe = 1'b1;
        lpc_reset = 1'b0;
        tick();
        lpc_reset = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        tests_run += 2;
        if (fifo_level !== 7'd0) begin tests_failed++; $display("FAIL rs_level: got %0d, expected 0", fifo_level); end
        if (tx_valid !== 1'b0)   begin tests_failed++; $display("FAIL rs_valid: got %b, expected 0", tx_valid); end
        in_strobe = 1'b0;
        tick();
        do_cap(4'h2, 16'h0045, 8'h45, 1'b0, 1'b1, 1'b0);
        wait_drain();
        tests_run++;
        if (exp_q.size() != 0) begin tests_failed++; $display("FAIL rs_drain: got %0d left, expected 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid();
        tx_ready = 1'b0;
        for (int i = 0; i < 4; i++) do_cap(4'h2, 16'h03C0 + 16'(i), 8'(i), 1'b0, 1'b0, 1'b0);
        exp_q.push_back(8'h20);
        exp_q.push_back(8'h03);
        tests_run++;
        if (fifo_level !== 7'd3) begin tests_failed++; $display("FAIL rm_level3: got %0d, expected 3", fifo_level); end
        tx_ready = 1'b1;
        tick();
        tick();
        tx_ready = 1'b0;
        tests_run++;
        if (tx_valid !== 1'b1 || tx_data !== 8'hC0) begin
            tests_failed++; $display("FAIL rm_alo: got valid=%b data=%02h, expected valid=1 data=c0", tx_valid, tx_data);
        end
        lpc_reset = 1'b0;
        #1;
        tests_run += 4;
        if (tx_valid !== 1'b0)   begin tests_failed++; $display("FAIL rm_valid: got %b, expected 0", tx_valid); end
        if (fifo_level !== 7'd0) begin tests_failed++; $display("FAIL rm_level: got %0d, expected 0", fifo_level); end
        if (tx_data !== 8'h00)   begin tests_failed++; $display("FAIL rm_data: got %02h, expected 00", tx_data); end
        if (exp_q.size() != 0)   begin tests_failed++; $display("FAIL rm_sent: got %0d unsent, expected 0", exp_q.size()); end
        exp_q.delete();
        tick();
        lpc_reset = 1'b1;
        tick();
        tx_ready = 1'b1;
        do_cap(4'h2, 16'h0400, 8'h99, 1'b0, 1'b1, 1'b0);
        wait_drain();
        tests_run++;
        if (exp_q.size() != 0) begin tests_failed++; $display("FAIL rm_drain: got %0d left, expected 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_overflow();
        test_filter();
        test_enable_strobe();
        test_reset_strobe();
        test_reset_mid();
        for (int i = 0; i < 4; i++) tick();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
